// File: rtl/thread_mt.sv
// thread_mt: round-robin multi-threaded RV32I-subset sequencer that drives one
// shared ALU/MEM port through a req/ack handshake.
package thread_mt_pkg;
    typedef enum logic [1:0] {
        UNIT_SEL_NONE = 2'd0,
        UNIT_SEL_ALU  = 2'd1,
        UNIT_SEL_MEM  = 2'd2
    } unit_sel_t;

    localparam logic [31:0] MEM_CTRL_READ = 32'd1;

    localparam logic [31:0] ALU_ADD  = 32'd0;
    localparam logic [31:0] ALU_SUB  = 32'd1;
    localparam logic [31:0] ALU_SLL  = 32'd2;
    localparam logic [31:0] ALU_SLT  = 32'd3;
    localparam logic [31:0] ALU_SLTU = 32'd4;
    localparam logic [31:0] ALU_XOR  = 32'd5;
    localparam logic [31:0] ALU_SRL  = 32'd6;
    localparam logic [31:0] ALU_SRA  = 32'd7;
    localparam logic [31:0] ALU_OR   = 32'd8;
    localparam logic [31:0] ALU_AND  = 32'd9;
    localparam logic [31:0] ALU_EQ   = 32'd10;
    localparam logic [31:0] ALU_NE   = 32'd11;
    localparam logic [31:0] ALU_GE   = 32'd12;
    localparam logic [31:0] ALU_GEU  = 32'd13;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
endpackage

module thread_mt
    import thread_mt_pkg::*;
#(
    parameter int          N_THREADS = 4,
    parameter int          N_REGS    = 32,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [31:0] PC_STRIDE = 32'h400,
    localparam int         TID_W     = $clog2(N_THREADS > 2 ? N_THREADS : 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_en,
    output logic                 unit_req,
    output unit_sel_t            unit_sel,
    output logic [31:0]          unit_ctrl,
    output logic [31:0]          unit_in [2],
    input  logic                 unit_ack,
    input  logic [31:0]          unit_out,
    output logic [TID_W-1:0]     cur_tid,
    output logic                 retire,
    output logic [N_THREADS-1:0] halted
);
    localparam int RW = $clog2(N_REGS);

    typedef enum logic [1:0] {SCHED, FETCH, EXEC, NEXT_PC} state_t;

    state_t           state;
    state_t           state_nx;
    logic             fresh;
    logic             found;
    logic [TID_W-1:0] pick;
    int               idx;

    logic [31:0] pc   [N_THREADS];
    logic [31:0] regs [N_THREADS][N_REGS];

    logic [31:0] inst;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        taken;
    logic [31:0] immed;
    logic [31:0] pc_cur;
    logic [31:0] alu_ctrl;
    logic [31:0] pc_res;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic        is_lui;
    logic        is_op;
    logic        is_imm;
    logic        is_br;
    logic        is_jal;
    logic        is_jalr;
    logic        uses_alu;
    logic        wr_en;
    logic [31:0] wr_data;

    assign opcode   = inst[6:0];
    assign f3       = inst[14:12];
    assign rd       = inst[7 +: RW];
    assign is_lui   = opcode == OPC_LUI;
    assign is_op    = opcode == OPC_OP;
    assign is_imm   = opcode == OPC_OP_IMM;
    assign is_br    = opcode == OPC_BRANCH;
    assign is_jal   = opcode == OPC_JAL;
    assign is_jalr  = opcode == OPC_JALR;
    assign uses_alu = is_op | is_imm | is_br | is_jal | is_jalr;
    assign pc_cur   = pc[cur_tid];

    // Operands are read straight off the fetched word during the fetch ack.
    assign rs1     = unit_out[15 +: RW];
    assign rs2     = unit_out[20 +: RW];
    assign rs1_val = (rs1 == '0) ? 32'd0 : regs[cur_tid][rs1];
    assign rs2_val = (rs2 == '0) ? 32'd0 : regs[cur_tid][rs2];
    assign pc_res  = is_jalr ? {unit_out[31:1], 1'b0} : unit_out;

    always_comb begin
        pick  = cur_tid;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_THREADS; i++) begin
            idx = (int'(cur_tid) + i + (fresh ? 0 : 1)) % N_THREADS;
            if (!found && !halted[idx[TID_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[TID_W-1:0];
            end
        end
    end

    always_comb begin
        immed = '0;
        unique case (1'b1)
            is_lui:  immed = {inst[31:12], 12'b0};
            is_br:   immed = {{20{inst[31]}}, inst[7], inst[30:25],
                              inst[11:8], 1'b0};
            is_jal:  immed = {{12{inst[31]}}, inst[19:12], inst[20],
                              inst[30:21], 1'b0};
            default: immed = {{20{inst[31]}}, inst[31:20]};
        endcase
    end

    always_comb begin
        alu_ctrl = ALU_ADD;
        if (is_br) begin
            unique case (f3)
                3'd1:    alu_ctrl = ALU_NE;
                3'd4:    alu_ctrl = ALU_SLT;
                3'd5:    alu_ctrl = ALU_GE;
                3'd6:    alu_ctrl = ALU_SLTU;
                3'd7:    alu_ctrl = ALU_GEU;
                default: alu_ctrl = ALU_EQ;
            endcase
        end else if (is_op || is_imm) begin
            unique case (f3)
                3'd0: alu_ctrl = (is_op && inst[30]) ? ALU_SUB : ALU_ADD;
                3'd1: alu_ctrl = ALU_SLL;
                3'd2: alu_ctrl = ALU_SLT;
                3'd3: alu_ctrl = ALU_SLTU;
                3'd4: alu_ctrl = ALU_XOR;
                3'd5: alu_ctrl = inst[30] ? ALU_SRA : ALU_SRL;
                3'd6: alu_ctrl = ALU_OR;
                3'd7: alu_ctrl = ALU_AND;
            endcase
        end
    end

    // Port outputs derive only from registered state, so they hold while stalled.
    always_comb begin
        state_nx   = state;
        unit_req   = 1'b0;
        unit_sel   = UNIT_SEL_NONE;
        unit_ctrl  = '0;
        unit_in[0] = '0;
        unit_in[1] = '0;
        retire     = 1'b0;
        unique case (state)
            SCHED: begin
                if (run_en && found) state_nx = FETCH;
            end
            FETCH: begin
                unit_req   = 1'b1;
                unit_sel   = UNIT_SEL_MEM;
                unit_ctrl  = MEM_CTRL_READ;
                unit_in[0] = pc_cur;
                if (unit_ack) state_nx = EXEC;
            end
            EXEC: begin
                unique case (1'b1)
                    is_lui: state_nx = NEXT_PC;
                    uses_alu: begin
                        unit_req   = 1'b1;
                        unit_sel   = UNIT_SEL_ALU;
                        unit_ctrl  = alu_ctrl;
                        unit_in[0] = (is_jal || is_jalr) ? pc_cur : op_a;
                        unit_in[1] = is_imm ? immed :
                                     (is_jal || is_jalr) ? 32'd4 : op_b;
                        if (unit_ack) state_nx = NEXT_PC;
                    end
                    default: state_nx = SCHED;
                endcase
            end
            NEXT_PC: begin
                unit_req   = 1'b1;
                unit_sel   = UNIT_SEL_ALU;
                unit_ctrl  = ALU_ADD;
                unit_in[0] = is_jalr ? op_a : pc_cur;
                unit_in[1] = (is_jalr || is_jal || (is_br && taken)) ?
                             immed : 32'd4;
                if (unit_ack) begin
                    retire   = 1'b1;
                    state_nx = SCHED;
                end
            end
            default: state_nx = SCHED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SCHED;
            cur_tid <= '0;
            fresh   <= 1'b1;
            halted  <= '0;
            inst    <= '0;
            op_a    <= '0;
            op_b    <= '0;
            taken   <= 1'b0;
            for (int t = 0; t < N_THREADS; t++)
                pc[t] <= RESET_PC + PC_STRIDE * 32'(t);
        end else begin
            state <= state_nx;
            unique case (state)
                SCHED: begin
                    if (run_en && found) begin
                        cur_tid <= pick;
                        fresh   <= 1'b0;
                    end
                end
                FETCH: begin
                    if (unit_ack) begin
                        inst <= unit_out;
                        op_a <= rs1_val;
                        op_b <= rs2_val;
                    end
                end
                EXEC: begin
                    if (unit_ack) taken <= is_br & unit_out[0];
                    if (!is_lui && !uses_alu) halted[cur_tid] <= 1'b1;
                end
                NEXT_PC: begin
                    if (unit_ack) pc[cur_tid] <= pc_res;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_data = unit_out;
        if (state == EXEC) begin
            if (is_lui) begin
                wr_en   = 1'b1;
                wr_data = immed;
            end else if (unit_ack && uses_alu && !is_br) begin
                wr_en = 1'b1;
            end
        end
    end

    // Register banks are deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en && rd != '0) regs[cur_tid][rd] <= wr_data;
    end
endmodule
